// File: rtl/matrix_stream_loader.sv
// Serial front-end for the 2x2 matrix adder: packs 4 A elements and 4 B elements, registers the sum.
// Optional macro MATRIX_LOADER_OVF_EN adds registered per-element carry-out flags (ovf_flags).
module matrix_stream_loader #(
    parameter int DATA_WIDTH  = 64,
    parameter int ELEM_WIDTH  = 16,
    parameter int MATRIX_SIZE = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ELEM_WIDTH-1:0]                in_data,
    output logic [DATA_WIDTH-1:0]                mat_a,
    output logic [DATA_WIDTH-1:0]                mat_b,
    input  logic [DATA_WIDTH-1:0]                add_result,
    output logic                                 out_valid,
    input  logic                                 out_ready,
`ifdef MATRIX_LOADER_OVF_EN
    output logic [MATRIX_SIZE*MATRIX_SIZE-1:0]   ovf_flags,
`endif
    output logic [DATA_WIDTH-1:0]                out_data
);

    localparam int NELEM = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CNT_W = $clog2(NELEM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NELEM - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        CAPTURE,
        OUT
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] matA_q;
    logic [DATA_WIDTH-1:0] matB_q;
    logic [DATA_WIDTH-1:0] outData_q;
    logic                  outValid_q;
    logic                  beat;

    // Ready depends on the state register alone, so nothing downstream can combinationally reach it.
    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat      = in_valid && in_ready;
    assign mat_a     = matA_q;
    assign mat_b     = matB_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;

`ifdef MATRIX_LOADER_OVF_EN
    logic [NELEM-1:0] ovf_d;
    logic [NELEM-1:0] ovfFlags_q;

    // A truncated sum smaller than an addend means the element add wrapped.
    always_comb begin
        ovf_d = '0;
        for (int k = 0; k < NELEM; k++) begin
            ovf_d[NELEM-1-k] =
                (ELEM_WIDTH'(matA_q[DATA_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH] +
                             matB_q[DATA_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH])
                 < matA_q[DATA_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH]);
        end
    end

    assign ovf_flags = ovfFlags_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            matA_q     <= '0;
            matB_q     <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
`ifdef MATRIX_LOADER_OVF_EN
            ovfFlags_q <= '0;
`endif
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (beat) begin
                        for (int k = 0; k < NELEM; k++) begin
                            if (cnt_q == k[CNT_W-1:0]) begin
                                matA_q[DATA_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH] <= in_data;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        for (int k = 0; k < NELEM; k++) begin
                            if (cnt_q == k[CNT_W-1:0]) begin
                                matB_q[DATA_WIDTH-1-k*ELEM_WIDTH -: ELEM_WIDTH] <= in_data;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    outData_q  <= add_result;
                    outValid_q <= 1'b1;
`ifdef MATRIX_LOADER_OVF_EN
                    ovfFlags_q <= ovf_d;
`endif
                    state_q    <= OUT;
                end
                OUT: begin
                    if (outValid_q && out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= LOAD_A;
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader: element-level model checked every cycle plus literal frame results.
// Builds with or without MATRIX_LOADER_OVF_EN.
module tb_matrix_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [63:0] mat_a;
    logic [63:0] mat_b;
    logic [63:0] add_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
`ifdef MATRIX_LOADER_OVF_EN
    logic [3:0]  ovf_flags;
`endif

    int nChecks = 0;
    int nFails  = 0;
    int cycleCnt = 0;
    int lastBeatCnt = 0;
    logic [63:0] outLog[$];
    int          outCyc[$];

    matrix_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mat_a      (mat_a),
        .mat_b      (mat_b),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MATRIX_LOADER_OVF_EN
        .ovf_flags  (ovf_flags),
`endif
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Stand-in for the combinational adder: four independent 16-bit wrapping adds.
    function automatic logic [63:0] addMat(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) r[63-16*k -: 16] = a[63-16*k -: 16] + b[63-16*k -: 16];
        return r;
    endfunction

    assign add_result = addMat(mat_a, mat_b);

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model state: element arrays, count of accepted beats, and what the outputs should show.
    int unsigned mdlA[4];
    int unsigned mdlB[4];
    int          beatIdx = 0;
    bit          modelValid = 0;
    bit          mdlInReady, mdlOutValid, mdlPending;
    logic [63:0] mdlOutData;
    logic [3:0]  mdlOvf;

    function automatic logic [63:0] packElems(input int unsigned e0, input int unsigned e1,
                                              input int unsigned e2, input int unsigned e3);
        return {16'(e0), 16'(e1), 16'(e2), 16'(e3)};
    endfunction

    // Outputs are compared at the falling edge; the model then advances using the inputs the next rising edge will see.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("in_ready", 64'(in_ready), 64'(mdlInReady));
            checkOutput("out_valid", 64'(out_valid), 64'(mdlOutValid));
            checkOutput("out_data", out_data, mdlOutData);
            checkOutput("mat_a", mat_a, packElems(mdlA[0], mdlA[1], mdlA[2], mdlA[3]));
            checkOutput("mat_b", mat_b, packElems(mdlB[0], mdlB[1], mdlB[2], mdlB[3]));
`ifdef MATRIX_LOADER_OVF_EN
            checkOutput("ovf_flags", 64'(ovf_flags), 64'(mdlOvf));
`endif
            if (out_valid && out_ready) begin
                outLog.push_back(out_data);
                outCyc.push_back(cycleCnt);
            end
        end
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mdlA[k] = 0;
                mdlB[k] = 0;
            end
            beatIdx     = 0;
            mdlInReady  = 1;
            mdlOutValid = 0;
            mdlPending  = 0;
            mdlOutData  = '0;
            mdlOvf      = '0;
            modelValid  = 1;
        end else if (modelValid) begin
            if (mdlPending) begin
                for (int k = 0; k < 4; k++) begin
                    mdlOutData[63-16*k -: 16] = 16'((mdlA[k] + mdlB[k]) % 65536);
                    mdlOvf[3-k] = ((mdlA[k] + mdlB[k]) > 65535);
                end
                mdlOutValid = 1;
                mdlPending  = 0;
            end else if (mdlOutValid) begin
                if (out_ready) begin
                    mdlOutValid = 0;
                    mdlInReady  = 1;
                end
            end else if (in_valid) begin
                if (beatIdx < 4) mdlA[beatIdx] = in_data;
                else             mdlB[beatIdx-4] = in_data;
                beatIdx++;
                if (beatIdx == 8) begin
                    beatIdx    = 0;
                    mdlInReady = 0;
                    mdlPending = 1;
                end
            end
        end
    end

    // Presents one element after some idle cycles and holds it until accepted; starts and ends at posedge+1.
    task automatic applyStimulus(input logic [15:0] d, input int gaps);
        int guard;
        in_valid = 1'b0;
        repeat (gaps) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL beat_accept: in_ready stuck at %0b, required 1", in_ready);
        end
        lastBeatCnt = cycleCnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [127:0] f, input int maxGap);
        for (int i = 0; i < 8; i++) applyStimulus(f[127-16*i -: 16], $urandom_range(0, maxGap));
    endtask

    task automatic waitOutput(input int count);
        int guard = 0;
        while (outLog.size() < count && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (outLog.size() < count) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL output_timeout: %0d results seen, required %0d", outLog.size(), count);
        end
    endtask

    localparam logic [127:0] FRAME_BASIC = 128'h0001_0002_0003_0004_000A_0014_001E_0028;
    localparam logic [127:0] FRAME_WRAP  = 128'hFFFF_8000_0000_0001_0001_8000_0000_FFFF;
    localparam logic [127:0] FRAME_FIVES = 128'h0005_0005_0005_0005_0001_0001_0001_0001;
    localparam logic [127:0] FRAME_TWO   = 128'h0064_00C8_012C_0190_0001_0002_0003_0004;
    localparam logic [63:0]  SUM_BASIC   = 64'h000B_0016_0021_002C;

    initial begin
        int prev;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", out_data, 64'd0);

        // Basic frame, with the last-beat-to-handshake distance pinned.
        prev = outLog.size();
        sendFrame(FRAME_BASIC, 0);
        waitOutput(prev + 1);
        if (outLog.size() > prev) begin
            checkOutput("basic_data", outLog[prev], SUM_BASIC);
            checkOutput("basic_latency", 64'(outCyc[prev] - lastBeatCnt), 64'd2);
        end

        // Every element wraps or is zero.
        prev = outLog.size();
        sendFrame(FRAME_WRAP, 0);
        waitOutput(prev + 1);
        if (outLog.size() > prev) checkOutput("wrap_data", outLog[prev], 64'd0);
`ifdef MATRIX_LOADER_OVF_EN
        checkOutput("wrap_ovf", 64'(ovf_flags), 64'b1101);
`endif

        // Output backpressure for five cycles.
        out_ready = 1'b0;
        prev = outLog.size();
        sendFrame(FRAME_BASIC, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_out_data", out_data, SUM_BASIC);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("release_count", 64'(outLog.size()), 64'(prev + 1));

        // Random input gaps must not change the result.
        prev = outLog.size();
        sendFrame(FRAME_BASIC, 3);
        waitOutput(prev + 1);
        if (outLog.size() > prev) checkOutput("gaps_data", outLog[prev], SUM_BASIC);

        // Reset after five beats discards the partial frame.
        prev = outLog.size();
        for (int i = 0; i < 5; i++) applyStimulus(FRAME_BASIC[127-16*i -: 16], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_mat_a", mat_a, 64'd0);
        checkOutput("midreset_mat_b", mat_b, 64'd0);
        sendFrame(FRAME_FIVES, 0);
        waitOutput(prev + 1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midreset_count", 64'(outLog.size()), 64'(prev + 1));
        if (outLog.size() > prev) checkOutput("midreset_data", outLog[prev], 64'h0006_0006_0006_0006);

        // Back-to-back frames, ten cycles per result.
        prev = outLog.size();
        sendFrame(FRAME_BASIC, 0);
        sendFrame(FRAME_TWO, 0);
        waitOutput(prev + 2);
        if (outLog.size() > prev + 1) begin
            checkOutput("b2b_first", outLog[prev], SUM_BASIC);
            checkOutput("b2b_second", outLog[prev+1], 64'h0065_00CA_012F_0194);
            checkOutput("b2b_spacing", 64'(outCyc[prev+1] - outCyc[prev]), 64'd10);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
